// File: rtl/xc_sha256_msched.sv
// SHA-256 message-schedule sequencer.
// Takes one 512-bit block as 16 words and streams W[0..63] on a valid/ready
// port. A 16-entry circular window holds the last 16 schedule words, and one
// shared sigma unit is switched between sigma0 (C0) and sigma1 (C1).

// Lightweight SHA-256 sigma unit: ss selects sigma0, sigma1, Sigma0, Sigma1.
module xc_sha256 (
  input  logic [31:0] rs1,
  input  logic [1:0]  ss,
  output logic [31:0] result
);

  logic [31:0] sig0;
  logic [31:0] sig1;
  logic [31:0] sum0;
  logic [31:0] sum1;

  assign sig0 = {rs1[6:0],  rs1[31:7]}  ^ {rs1[17:0], rs1[31:18]} ^ {3'b000, rs1[31:3]};
  assign sig1 = {rs1[16:0], rs1[31:17]} ^ {rs1[18:0], rs1[31:19]} ^ {10'b0, rs1[31:10]};
  assign sum0 = {rs1[1:0],  rs1[31:2]}  ^ {rs1[12:0], rs1[31:13]} ^ {rs1[21:0], rs1[31:22]};
  assign sum1 = {rs1[5:0],  rs1[31:6]}  ^ {rs1[10:0], rs1[31:11]} ^ {rs1[24:0], rs1[31:25]};

  // Pick the requested function of the operand.
  always_comb begin
    result = sig0;
    case (ss)
      2'b00:   result = sig0;
      2'b01:   result = sig1;
      2'b10:   result = sum0;
      default: result = sum1;
    endcase
  end

endmodule

module xc_sha256_msched (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        abort,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_idx,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, C0, C1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] win [16];
  logic [31:0] acc;
  logic [3:0]  cnt;
  logic [5:0]  t;

  // Window slots are the schedule index modulo 16; 4-bit adds wrap for free.
  logic [3:0]  slot;
  logic [3:0]  slot_p1;
  logic [3:0]  slot_p9;
  logic [3:0]  slot_p14;
  logic [1:0]  sig_sel;
  logic [31:0] sig_in;
  logic [31:0] sig_out;

  assign slot     = t[3:0];
  assign slot_p1  = slot + 4'd1;
  assign slot_p9  = slot + 4'd9;
  assign slot_p14 = slot + 4'd14;

  assign w_data = win[slot];
  assign w_idx  = t;

  xc_sha256 u_sigma (
    .rs1    (sig_in),
    .ss     (sig_sel),
    .result (sig_out)
  );

  // State register; reset parks the sequencer in IDLE.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state, handshake outputs and sigma operand selection; abort overrides.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    w_valid    = 1'b0;
    busy       = 1'b0;
    sig_sel    = 2'b00;
    sig_in     = win[slot_p1];
    case (state)
      IDLE: begin
        state_nxt = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid && (cnt == 4'd15)) begin
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        if (w_ready) begin
          if (t == 6'd63) begin
            state_nxt = LOAD;
          end else if (t < 6'd15) begin
            state_nxt = EMIT;
          end else begin
            state_nxt = C0;
          end
        end
      end
      C0: begin
        busy      = 1'b1;
        sig_sel   = 2'b00;
        sig_in    = win[slot_p1];
        state_nxt = C1;
      end
      C1: begin
        busy      = 1'b1;
        sig_sel   = 2'b01;
        sig_in    = win[slot_p14];
        state_nxt = EMIT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort) begin
      state_nxt = LOAD;
    end
  end

  // Window, accumulator and counters: load words, step t, and build W[t] in C0/C1.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
      acc <= '0;
      cnt <= '0;
      t   <= '0;
    end else if (abort) begin
      cnt <= '0;
      t   <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (load_valid) begin
            win[cnt] <= load_data;
            if (cnt == 4'd15) begin
              cnt <= '0;
              t   <= '0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        EMIT: begin
          if (w_ready) begin
            if (t == 6'd63) begin
              cnt <= '0;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        C0: begin
          acc <= win[slot] + sig_out;
        end
        C1: begin
          win[slot] <= acc + sig_out + win[slot_p9];
        end
        default: begin
        end
      endcase
    end
  end

endmodule
